// File: rtl/bcd_serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial BCD adder.
// The master drives the operands and start; the slave returns the status and result registers.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  c_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  c_out;
    logic                  error;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, error
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, error
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder that reuses one single-digit BCD adder.
// It processes one digit per clock, least-significant digit first, under a start/done controller.

// Single-digit BCD adder: a binary add followed by the +6 correction when the raw sum exceeds 9.
module bcd_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw   = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
        adj   = raw + 5'd6;
        c_out = (raw > 5'd9);
        sum   = c_out ? adj[3:0] : raw[3:0];
    end
endmodule

module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    bcd_serial_adder_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic            err_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [W-1:0]    sum_reg;
    logic            c_out_reg;
    logic            error_reg;

    logic [3:0]      dig_sum;
    logic            dig_cout;
    logic            dig_bad;
    logic            err_next;
    logic [W-1:0]    res_next;

    bcd_adder u_digit (
        .a     (a_reg[3:0]),
        .b     (b_reg[3:0]),
        .c_in  (carry_reg),
        .sum   (dig_sum),
        .c_out (dig_cout)
    );

    // A digit is illegal when it is 10..15, i.e. bit 3 set with bit 2 or bit 1 set.
    always_comb begin
        dig_bad  = (a_reg[3] & (a_reg[2] | a_reg[1])) |
                   (b_reg[3] & (b_reg[2] | b_reg[1]));
        err_next = err_reg | dig_bad;
        // The new digit enters at the top; after DIGITS shifts digit 0 sits in bits [3:0].
        res_next = W'({dig_sum, res_reg} >> 4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.c_in;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end
                end

                ADD: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    res_reg   <= res_next;
                    carry_reg <= dig_cout;
                    err_reg   <= err_next;
                    if (cnt_reg == LAST_DIGIT) begin
                        // Last digit: publish results, or force a clean zero on any illegal digit.
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        if (err_next) begin
                            sum_reg   <= '0;
                            c_out_reg <= 1'b0;
                            error_reg <= 1'b1;
                        end else begin
                            sum_reg   <= res_next;
                            c_out_reg <= dig_cout;
                            error_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.sum   = sum_reg;
    assign bus.c_out = c_out_reg;
    assign bus.error = error_reg;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: a 4-digit instance and a 1-digit instance share clock and reset.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_bcd_serial_adder;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    bcd_serial_adder_if #(.DIGITS(4)) bus4 ();
    bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one 4-digit operation. It returns the edges from accept to done, the busy-high samples,
    // the samples with busy and done high together, and the outputs seen with done.
    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output int lat, output int busy_cnt, output int overlap,
                          output logic [15:0] s, output logic co, output logic er);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a = a;
        bus4.b = b;
        bus4.c_in = cin;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        overlap = 0;
        if (bus4.busy === 1'b1) busy_cnt++;
        while (bus4.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus4.busy === 1'b1) busy_cnt++;
            if (bus4.busy === 1'b1 && bus4.done === 1'b1) overlap++;
        end
        s = bus4.sum;
        co = bus4.c_out;
        er = bus4.error;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus4.busy, bus4.done, bus4.c_out, bus4.error} !== 4'b0000 || bus4.sum !== 16'h0000) begin
            n_err++;
            $display("FAIL reset4: busy=%b done=%b sum=%h c_out=%b error=%b, need all 0",
                     bus4.busy, bus4.done, bus4.sum, bus4.c_out, bus4.error);
        end
        n_vec++;
        if ({bus1.busy, bus1.done, bus1.c_out, bus1.error} !== 4'b0000 || bus1.sum !== 4'h0) begin
            n_err++;
            $display("FAIL reset1: busy=%b done=%b sum=%h c_out=%b error=%b, need all 0",
                     bus1.busy, bus1.done, bus1.sum, bus1.c_out, bus1.error);
        end
        reset_n = 1'b1;
        $display("reset: applied and released");
    endtask

    task automatic test_basic;
        int lat, bc, ov;
        logic [15:0] s;
        logic co, er;
        do_op4(16'h1234, 16'h5678, 1'b0, lat, bc, ov, s, co, er);
        $display("op 1234+5678+0: lat=%0d busy=%0d sum=%h c_out=%b error=%b", lat, bc, s, co, er);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d, need 4", lat); end
        n_vec++; if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d, need 4", bc); end
        n_vec++; if (ov !== 0) begin n_err++; $display("FAIL basic_busy_done_overlap: got %0d, need 0", ov); end
        n_vec++; if (s !== 16'h6912) begin n_err++; $display("FAIL basic_sum: got %h, need 6912", s); end
        n_vec++; if (co !== 1'b0 || er !== 1'b0) begin n_err++; $display("FAIL basic_flags: c_out=%b error=%b, need 0 0", co, er); end
        @(negedge clk);
        n_vec++; if (bus4.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: done=%b one cycle later, need 0", bus4.done); end
    endtask

    task automatic test_carry;
        int lat, bc, ov;
        logic [15:0] s;
        logic co, er;
        do_op4(16'h9999, 16'h0001, 1'b0, lat, bc, ov, s, co, er);
        $display("op 9999+0001+0: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (s !== 16'h0000 || co !== 1'b1 || er !== 1'b0) begin
            n_err++; $display("FAIL carry_ripple: sum=%h c_out=%b error=%b, need 0000 1 0", s, co, er);
        end
        do_op4(16'h0000, 16'h0000, 1'b1, lat, bc, ov, s, co, er);
        $display("op 0000+0000+1: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (s !== 16'h0001 || co !== 1'b0 || er !== 1'b0) begin
            n_err++; $display("FAIL carry_in: sum=%h c_out=%b error=%b, need 0001 0 0", s, co, er);
        end
        do_op4(16'h4567, 16'h5432, 1'b1, lat, bc, ov, s, co, er);
        $display("op 4567+5432+1: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (s !== 16'h0000 || co !== 1'b1) begin
            n_err++; $display("FAIL carry_chain: sum=%h c_out=%b, need 0000 1", s, co);
        end
    endtask

    task automatic test_error;
        int lat, bc, ov;
        logic [15:0] s;
        logic co, er;
        do_op4(16'h12A4, 16'h0000, 1'b0, lat, bc, ov, s, co, er);
        $display("op 12A4+0000+0: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL error_flag: got %b, need 1", er); end
        n_vec++; if (s !== 16'h0000 || co !== 1'b0) begin n_err++; $display("FAIL error_zero: sum=%h c_out=%b, need 0000 0", s, co); end
        do_op4(16'h0005, 16'h0004, 1'b0, lat, bc, ov, s, co, er);
        $display("op 0005+0004+0: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (er !== 1'b0 || s !== 16'h0009 || co !== 1'b0) begin
            n_err++; $display("FAIL error_clears: sum=%h c_out=%b error=%b, need 0009 0 0", s, co, er);
        end
        do_op4(16'h0000, 16'hF000, 1'b0, lat, bc, ov, s, co, er);
        $display("op 0000+F000+0 (illegal top digit of b): sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (er !== 1'b1 || s !== 16'h0000) begin
            n_err++; $display("FAIL error_last_digit: sum=%h error=%b, need 0000 1", s, er);
        end
    endtask

    // start held high: accepts at E0 and E6, so done appears at n=4 and n=10.
    task automatic test_back_to_back;
        int done_cnt, ov;
        int first_done, second_done;
        logic [15:0] s_first, s_second;
        done_cnt = 0; ov = 0; first_done = -1; second_done = -1;
        s_first = '0; s_second = '0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 16'h0001; bus4.b = 16'h0001; bus4.c_in = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.busy === 1'b1 && bus4.done === 1'b1) ov++;
            if (bus4.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin first_done = n; s_first = bus4.sum; end
                else begin second_done = n; s_second = bus4.sum; end
            end
            if (n == 0) begin bus4.a = 16'h0033; bus4.b = 16'h0044; end
            if (n == 4) begin bus4.a = 16'h0001; bus4.b = 16'h0002; end
            if (n == 11) bus4.start = 1'b0;
        end
        $display("back_to_back: dones=%0d at n=%0d,%0d sums=%h,%h", done_cnt, first_done, second_done, s_first, s_second);
        n_vec++; if (done_cnt !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d, need 2", done_cnt); end
        n_vec++; if (first_done !== 4 || second_done !== 10) begin
            n_err++; $display("FAIL b2b_done_spacing: at %0d,%0d, need 4,10", first_done, second_done);
        end
        n_vec++; if (s_first !== 16'h0002) begin n_err++; $display("FAIL b2b_operand_hold: got %h, need 0002", s_first); end
        n_vec++; if (s_second !== 16'h0003) begin n_err++; $display("FAIL b2b_second_sum: got %h, need 0003", s_second); end
        n_vec++; if (ov !== 0) begin n_err++; $display("FAIL b2b_busy_done_overlap: got %0d, need 0", ov); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, ov, late_done;
        logic [15:0] s;
        logic co, er;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 16'h9999; bus4.b = 16'h9999; bus4.c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.sum !== 16'h0000 || bus4.error !== 1'b0 || bus4.c_out !== 1'b0) begin
            n_err++; $display("FAIL async_reset: busy=%b done=%b sum=%h c_out=%b error=%b, need all 0",
                              bus4.busy, bus4.done, bus4.sum, bus4.c_out, bus4.error);
        end
        @(negedge clk);
        reset_n = 1'b1;
        late_done = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.done === 1'b1 || bus4.busy === 1'b1) late_done++;
        end
        $display("reset mid-ADD: activity after release=%0d", late_done);
        n_vec++; if (late_done !== 0) begin n_err++; $display("FAIL reset_abort: busy/done seen %0d times, need 0", late_done); end
        do_op4(16'h9999, 16'h9999, 1'b0, lat, bc, ov, s, co, er);
        $display("op 9999+9999+0: sum=%h c_out=%b error=%b", s, co, er);
        n_vec++; if (s !== 16'h9998 || co !== 1'b1 || er !== 1'b0) begin
            n_err++; $display("FAIL after_reset_sum: sum=%h c_out=%b error=%b, need 9998 1 0", s, co, er);
        end
    endtask

    task automatic test_one_digit;
        int lat;
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = 4'h8; bus1.b = 4'h7; bus1.c_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 0;
        while (bus1.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        $display("op1 8+7+1: lat=%0d sum=%h c_out=%b error=%b", lat, bus1.sum, bus1.c_out, bus1.error);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL one_digit_latency: got %0d, need 1", lat); end
        n_vec++; if (bus1.sum !== 4'h6 || bus1.c_out !== 1'b1 || bus1.error !== 1'b0) begin
            n_err++; $display("FAIL one_digit_sum: sum=%h c_out=%b error=%b, need 6 1 0", bus1.sum, bus1.c_out, bus1.error);
        end
        @(negedge clk);
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = 4'hC; bus1.b = 4'h1; bus1.c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 0;
        while (bus1.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        $display("op1 C+1+0: lat=%0d sum=%h c_out=%b error=%b", lat, bus1.sum, bus1.c_out, bus1.error);
        n_vec++; if (bus1.error !== 1'b1 || bus1.sum !== 4'h0 || bus1.c_out !== 1'b0) begin
            n_err++; $display("FAIL one_digit_error: sum=%h c_out=%b error=%b, need 0 0 1", bus1.sum, bus1.c_out, bus1.error);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_basic;
        test_carry;
        test_error;
        test_back_to_back;
        test_reset_mid;
        test_one_digit;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
